// File: rtl/shiftreg_in.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_in
// Purpose  : Framed serial-to-parallel receiver. Data arrives MSB first,
//            qualified by frame. A shift register and bit counter feed a
//            double-buffered holding register with a valid/ack handshake.
//            Each frame yields at most one byte. A frame that is cut short
//            raises a one-cycle frame_error pulse.
// Option   : SHIFTREG_IN_OVERRUN_EN
//            When defined, a byte that completes while the holding register
//            is still unread is discarded and the sticky overrun flag is set.
//            When undefined, that byte overwrites the holding register and
//            overrun is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_in (
  input  logic       serial_clk,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       frame,
  input  logic       data_ack,
  input  logic       overrun_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_error,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  shift_data_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        busy_q;
  logic        frame_error_q;
  logic [7:0]  byte_d;

  // The byte as it stands once the current bit is appended (valid on the 8th bit)
  assign byte_d = {shift_data_q[6:0], serial_in};

`ifdef SHIFTREG_IN_OVERRUN_EN
  logic overrun_q;
`else
  logic w_unused;
  assign w_unused = overrun_clr;
`endif

  // Receive FSM, shift path, holding register and status flags
  always_ff @(posedge serial_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shift_data_q  <= 8'h00;
      bit_cnt_q     <= 4'd0;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef SHIFTREG_IN_OVERRUN_EN
      overrun_q     <= 1'b0;
`endif
    end else begin
      frame_error_q <= 1'b0;

      // A consumer read empties the holding register; a completion below may refill it
      if (data_ack && data_valid_q) begin
        data_valid_q <= 1'b0;
      end

`ifdef SHIFTREG_IN_OVERRUN_EN
      // Clear first so that a coinciding overrun event below takes priority
      if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
`endif

      case (state_q)
        IDLE: begin
          if (frame) begin
            shift_data_q <= {7'h00, serial_in};
            bit_cnt_q    <= 4'd1;
            state_q      <= SHIFT;
            busy_q       <= 1'b1;
          end
        end

        SHIFT: begin
          if (!frame) begin
            // Frame ended early: drop the partial byte, holding register untouched
            shift_data_q  <= 8'h00;
            bit_cnt_q     <= 4'd0;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b1;
          end else if (bit_cnt_q == 4'd7) begin
            shift_data_q <= byte_d;
            bit_cnt_q    <= 4'd0;
            state_q      <= WAIT_IDLE;
            busy_q       <= 1'b0;
`ifdef SHIFTREG_IN_OVERRUN_EN
            if (data_valid_q && !data_ack) begin
              overrun_q <= 1'b1;
            end else begin
              data_out_q   <= byte_d;
              data_valid_q <= 1'b1;
            end
`else
            data_out_q   <= byte_d;
            data_valid_q <= 1'b1;
`endif
          end else begin
            shift_data_q <= byte_d;
            bit_cnt_q    <= bit_cnt_q + 4'd1;
          end
        end

        WAIT_IDLE: begin
          // Remaining bits of an over-long frame are ignored
          if (!frame) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= 4'd0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
`ifdef SHIFTREG_IN_OVERRUN_EN
  assign overrun     = overrun_q;
`else
  assign overrun     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_in
// Purpose  : Directed self-checking bench for shiftreg_in. Expectations
//            follow SHIFTREG_IN_OVERRUN_EN if that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_in;

  logic       serial_clk;
  logic       reset_n;
  logic       serial_in;
  logic       frame;
  logic       data_ack;
  logic       overrun_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_error;
  logic       overrun;

  int checks;
  int errors;

  shiftreg_in dut (
    .serial_clk  (serial_clk),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .frame       (frame),
    .data_ack    (data_ack),
    .overrun_clr (overrun_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  initial serial_clk = 1'b0;
  always #5 serial_clk = ~serial_clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge serial_clk);
    #1;
  endtask

  // Drive a whole 8-bit frame, MSB first, leaving frame high after the last bit
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      frame     = 1'b1;
      serial_in = b[i];
      tick();
    end
  endtask

  task automatic end_frame();
    frame     = 1'b0;
    serial_in = 1'b1;
    tick();
  endtask

  task automatic ack_byte();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; serial_in = 1'b1; frame = 1'b0; data_ack = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h expected 00", data_out); end
    checks++;
    if ({data_valid, busy, frame_error, overrun} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {data_valid, busy, frame_error, overrun});
    end
    reset_n = 1'b1;
    tick();
  endtask

  // 8'hA5 = 1,0,1,0,0,1,0,1; busy high after bits 1..7, byte visible after bit 8
  task automatic test_basic_byte();
    logic [7:0] pat;
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      frame = 1'b1; serial_in = pat[i];
      tick();
      if (i > 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy bit %0d got %b expected 1", 8 - i, busy); end
      end
    end
    checks++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_byte got %h v%b b%b expected a5 v1 b0", data_out, data_valid, busy);
    end
    end_frame();
    ack_byte();
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got %b expected 0", data_valid); end
  endtask

  // Over-long frame: extra bits ignored, exactly one byte
  task automatic test_wait_idle();
    send_byte(8'h3C);
    for (int k = 0; k < 3; k++) begin
      frame = 1'b1; serial_in = k[0];
      tick();
      checks++;
      if (data_out !== 8'h3C || data_valid !== 1'b1 || busy !== 1'b0 || frame_error !== 1'b0) begin
        errors++; $display("FAIL wait_idle cyc %0d got %h v%b b%b fe%b expected 3c v1 b0 fe0",
                            k, data_out, data_valid, busy, frame_error);
      end
    end
    end_frame();
    checks++;
    if (busy !== 1'b0 || frame_error !== 1'b0 || data_out !== 8'h3C) begin
      errors++; $display("FAIL wait_idle_exit got %h b%b fe%b expected 3c b0 fe0", data_out, busy, frame_error);
    end
    ack_byte();
  endtask

  // Short frame of 5 bits aborts with a single frame_error pulse
  task automatic test_abort();
    data_ack = 1'b1;  // ack with nothing valid must be harmless
    for (int k = 0; k < 5; k++) begin
      frame = 1'b1; serial_in = 1'b0;
      tick();
    end
    data_ack = 1'b0;
    end_frame();
    checks++;
    if (frame_error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_pulse got fe%b b%b expected fe1 b0", frame_error, busy);
    end
    checks++;
    if (data_out !== 8'h3C || data_valid !== 1'b0) begin
      errors++; $display("FAIL abort_hold got %h v%b expected 3c v0", data_out, data_valid);
    end
    tick();
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL abort_pulse_len got %b expected 0", frame_error); end
  endtask

  task automatic test_overrun();
    send_byte(8'h11);
    end_frame();
    send_byte(8'h22);
`ifdef SHIFTREG_IN_OVERRUN_EN
    checks++;
    if (data_out !== 8'h11 || data_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL overrun got %h v%b o%b expected 11 v1 o1", data_out, data_valid, overrun);
    end
    end_frame();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b expected 1", overrun); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b expected 0", overrun); end
`else
    checks++;
    if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL overrun got %h v%b o%b expected 22 v1 o0", data_out, data_valid, overrun);
    end
    end_frame();
`endif
    ack_byte();
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL overrun_ack got %b expected 0", data_valid); end
  endtask

  // Ack on the completion edge loads the new byte without overrun
  task automatic test_back_to_back();
    logic [7:0] pat;
    send_byte(8'h11);
    end_frame();
    pat = 8'h22;
    for (int i = 7; i >= 0; i--) begin
      frame = 1'b1; serial_in = pat[i];
      data_ack = (i == 0);
      tick();
    end
    data_ack = 1'b0;
    checks++;
    if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ack_collide got %h v%b o%b expected 22 v1 o0", data_out, data_valid, overrun);
    end
    end_frame();
  endtask

  // Reset after bit 4 of a frame, then a full 8'hFF frame starting as reset releases
  task automatic test_reset_midframe();
    for (int k = 0; k < 4; k++) begin
      frame = 1'b1; serial_in = 1'b1;
      tick();
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({data_out, data_valid, busy, frame_error, overrun} !== 12'h000) begin
      errors++; $display("FAIL reset_async got %h v%b b%b fe%b o%b expected all 0",
                          data_out, data_valid, busy, frame_error, overrun);
    end
    frame = 1'b0;
    tick();
    checks++;
    if (frame_error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_ferr got fe%b b%b expected fe0 b0", frame_error, busy);
    end
    reset_n = 1'b1;
    send_byte(8'hFF);
    checks++;
    if (data_out !== 8'hFF || data_valid !== 1'b1 || frame_error !== 1'b0) begin
      errors++; $display("FAIL reset_next_frame got %h v%b fe%b expected ff v1 fe0", data_out, data_valid, frame_error);
    end
    end_frame();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_byte();
    test_wait_idle();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shiftreg_in.md
SHIFTREG_IN -- requirements
Module: shiftreg_in

Interface
REQ-001 serial_clk  input  1  single clock, all state updates on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous and active-low.
REQ-003 serial_in  input  1  serial data, MSB first, idle level 1.
REQ-004 frame  input  1  frame qualifier, driven by the transmitter's busy; 1 = serial_in carries a data bit this cycle.
REQ-005 data_ack  input  1  consumer read strobe, sampled on serial_clk.
REQ-006 overrun_clr  input  1  clears the sticky overrun flag.
REQ-007 data_out  output  8  holding register, last completed byte.
REQ-008 data_valid  output  1  holding register holds an unread byte.
REQ-009 busy  output  1  frame reception in progress (state SHIFT).
REQ-010 frame_error  output  1  one-cycle pulse, frame aborted before 8 bits.
REQ-011 overrun  output  1  sticky, byte completed while holding register unread.

Function
REQ-012 The block SHALL be double buffered: shift register shift_data[7:0] and bit counter bit_cnt[3:0] feed holding register data_out.
REQ-013 States SHALL be IDLE, SHIFT and WAIT_IDLE.
REQ-014 IDLE, frame=1: SHALL shift serial_in into shift_data[0], set bit_cnt=1, go to SHIFT; frame=0: SHALL stay in IDLE.
REQ-015 SHIFT, frame=1, bit_cnt<7: SHALL shift left, capture serial_in into bit 0 and increment bit_cnt.
REQ-016 SHIFT, frame=1, bit_cnt=7: SHALL complete the byte {shift_data[6:0],serial_in}, clear bit_cnt and go to WAIT_IDLE.
REQ-017 On byte completion, data_out and data_valid SHALL be updated on that same edge, so a byte is visible one cycle after its 8th bit is sampled.
REQ-018 SHIFT, frame=0: SHALL abort, discard the partial byte, clear bit_cnt, go to IDLE and pulse frame_error high for exactly one cycle; data_out and data_valid SHALL be unchanged.
REQ-019 WAIT_IDLE SHALL ignore serial_in; frame=0 SHALL go to IDLE, frame=1 SHALL stay in WAIT_IDLE, so each frame yields at most one byte.
REQ-020 busy SHALL be 1 exactly while in SHIFT.
REQ-021 data_ack=1 with data_valid=1 SHALL clear data_valid on that edge; data_ack with data_valid=0 SHALL have no effect.
REQ-022 Completion and data_ack on the same edge SHALL load the new byte, keep data_valid=1 and not flag overrun.
REQ-023 Completion with data_valid=1 and no data_ack is an overrun, handled per REQ-030/031.
REQ-024 overrun_clr SHALL clear overrun; if it coincides with a new overrun event, set SHALL win.
REQ-025 bit_cnt SHALL never exceed 7; there is no wrap-around within a frame.

Reset
REQ-026 reset_n=0 SHALL immediately and asynchronously force state=IDLE, shift_data=0, bit_cnt=0.
REQ-027 Reset SHALL force data_out=8'h00, data_valid=0, busy=0, frame_error=0 and overrun=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte without pulsing frame_error.
REQ-029 After reset_n deasserts with frame=1, the block SHALL treat that cycle as the first bit of a frame, per REQ-014.

Configuration
REQ-030 With macro SHIFTREG_IN_OVERRUN_EN defined, an overrun SHALL discard the new byte, retain data_out and data_valid, and set overrun until overrun_clr or reset.
REQ-031 Without SHIFTREG_IN_OVERRUN_EN, an overrun SHALL overwrite data_out with the new byte and keep data_valid=1; overrun SHALL be tied 0 and overrun_clr ignored.

Verification
REQ-032 Reset, then frame=1 for 8 cycles with serial_in=1,0,1,0,0,1,0,1 -> busy=1 during bits 1-7; data_out=8'hA5, data_valid=1 one cycle after the 8th bit.
REQ-033 Frame of 8'h3C, frame held high 3 extra cycles with serial_in toggling -> data_out=8'h3C, single byte, stays in WAIT_IDLE until frame=0.
REQ-034 frame=1 for 5 cycles, then 0 -> frame_error pulses 1 cycle; data_out and data_valid unchanged; busy=0.
REQ-035 Byte 8'h11 unread, second frame 8'h22 completes -> with macro: data_out=8'h11, overrun=1; without: data_out=8'h22, overrun=0.
REQ-036 Byte 8'h11 valid, data_ack asserted on the completion edge of 8'h22 -> data_out=8'h22, data_valid=1, overrun=0.
REQ-037 reset_n pulsed low after bit 4 of a frame -> all outputs zero immediately; no frame_error pulse; next full frame 8'hFF received correctly.
